// File: rtl/imem_pkg.sv
// Shared types for the instruction memory loader: FSM states and NOP word.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    localparam int IMEM_NOP = 0;

endpackage

// File: rtl/imem_loader_if.sv
// Fetch port between the CPU fetch stage (master) and imem_loader (slave).
interface imem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 6
);
    logic              fetch_req;
    logic [AW-1:0]     fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_oob;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_valid, fetch_data, fetch_oob
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_valid, fetch_data, fetch_oob
    );
endinterface

// File: rtl/imem_ram.sv
// Single write port, single registered read port; array has no reset.
module imem_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/imem_loader.sv
// Serially loaded instruction memory with registered fetch port.
// Optional load checksum output: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [DATA_W-1:0] Instruction,
    imem_fetch_if.slave       fetch,
    output logic              ready,
    output logic [AW:0]       prog_len,
    output logic              overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,output logic [DATA_W-1:0] load_csum
`endif
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t            r_state, w_nxt;
    logic [AW:0]       r_prog_len;
    logic              r_ovf;
    logic              r_valid;
    logic              r_oob;
    logic              r_zero;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic              w_start;
    logic              w_inc;
    logic              w_ovf_set;
    logic              w_rd;
    logic              w_oob;
    logic              w_full;
    logic [DATA_W-1:0] w_rdata;

    assign w_full = (r_prog_len == FULL);
    assign w_oob  = ({1'b0, fetch.fetch_addr} >= r_prog_len);

    always_comb begin
        w_nxt     = r_state;
        w_we      = 1'b0;
        w_waddr   = '0;
        w_start   = 1'b0;
        w_inc     = 1'b0;
        w_ovf_set = 1'b0;
        w_rd      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (LoadInstructions) begin
                    w_we    = 1'b1;
                    w_start = 1'b1;
                    w_nxt   = ST_LOADING;
                end
            end
            ST_LOADING: begin
                if (!LoadInstructions) begin
                    w_nxt = ST_READY;
                end else if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = r_prog_len[AW-1:0];
                    w_inc   = 1'b1;
                end
            end
            ST_READY: begin
                // A reload wins over a same-cycle fetch
                if (LoadInstructions) begin
                    w_we    = 1'b1;
                    w_start = 1'b1;
                    w_nxt   = ST_LOADING;
                end else if (fetch.fetch_req) begin
                    w_rd = 1'b1;
                end
            end
            default: w_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= ST_EMPTY;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_prog_len <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_oob      <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            if (w_start) begin
                r_prog_len <= (AW+1)'(1);
                r_ovf      <= 1'b0;
            end else if (w_inc) begin
                r_prog_len <= r_prog_len + (AW+1)'(1);
            end
            if (w_ovf_set) r_ovf <= 1'b1;
            r_valid <= w_rd;
            r_oob   <= w_rd & w_oob;
            // RAM output has no reset, so a flag masks it to NOP
            if (w_rd) r_zero <= w_oob;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (Instruction),
        .i_re    (w_rd & ~w_oob),
        .i_raddr (fetch.fetch_addr),
        .o_rdata (w_rdata)
    );

    assign fetch.fetch_valid = r_valid;
    assign fetch.fetch_oob   = r_oob;
    assign fetch.fetch_data  = r_zero ? DATA_W'(IMEM_NOP) : w_rdata;
    assign ready             = (r_state == ST_READY);
    assign prog_len          = r_prog_len;
    assign overflow          = r_ovf;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)       r_csum <= '0;
        else if (w_start) r_csum <= Instruction;
        else if (w_inc)   r_csum <= r_csum ^ Instruction;
    end

    assign load_csum = r_csum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized + directed bench for imem_loader against a word-level model.
module tb_imem_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          Reset;
    logic          LoadInstructions;
    logic [DW-1:0] Instruction;
    logic          ready;
    logic [AW:0]   prog_len;
    logic          overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] load_csum;
`endif

    imem_fetch_if #(.DATA_W(DW), .AW(AW)) fif ();

    imem_loader #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .fetch            (fif),
        .ready            (ready),
        .prog_len         (prog_len),
        .overflow         (overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
       ,.load_csum        (load_csum)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: program as a word array plus its length and mode
    typedef enum int {M_EMPTY, M_LOADING, M_READY} mode_t;
    mode_t         mode_m;
    logic [DW-1:0] mem_m [DEPTH];
    int            len_m;
    bit            ovf_m;
    bit            exp_v;
    bit            exp_oob;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] csum_m;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mode_m  = M_EMPTY;
        len_m   = 0;
        ovf_m   = 0;
        exp_v   = 0;
        exp_oob = 0;
        exp_d   = '0;
        csum_m  = '0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_valid"}, 64'(fif.fetch_valid), 64'(exp_v));
        check({tag, "_oob"},   64'(fif.fetch_oob),   64'(exp_oob));
        check({tag, "_data"},  64'(fif.fetch_data),  64'(exp_d));
        check({tag, "_ready"}, 64'(ready), 64'(mode_m == M_READY));
        check({tag, "_len"},   64'(prog_len),  64'(len_m));
        check({tag, "_ovf"},   64'(overflow),  64'(ovf_m));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({tag, "_csum"},  64'(load_csum), 64'(csum_m));
`endif
    endtask

    task automatic cyc(input bit ld, input logic [DW-1:0] ins,
                       input bit rq, input int ad);
        LoadInstructions = ld;
        Instruction      = ins;
        fif.fetch_req    = rq;
        fif.fetch_addr   = AW'(ad);
        exp_v   = (mode_m == M_READY) && rq && !ld;
        exp_oob = exp_v && (ad >= len_m);
        if (exp_v) exp_d = exp_oob ? '0 : mem_m[ad];
        if (ld) begin
            if (mode_m != M_LOADING) begin
                mem_m[0] = ins;
                len_m    = 1;
                ovf_m    = 0;
                csum_m   = ins;
                mode_m   = M_LOADING;
            end else if (len_m < DEPTH) begin
                mem_m[len_m] = ins;
                len_m++;
                csum_m ^= ins;
            end else begin
                ovf_m = 1;
            end
        end else if (mode_m == M_LOADING) begin
            mode_m = M_READY;
        end
        @(posedge clk);
        #1;
        check_outs("cyc");
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0);
    endtask

    task automatic fetch1(input int ad);
        cyc(0, DW'($urandom), 1, ad);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any edge
    task automatic arst();
        LoadInstructions = 0;
        fif.fetch_req    = 0;
        #3;
        Reset = 0;
        #1;
        model_reset();
        check_outs("arst");
        @(posedge clk);
        #1;
        Reset = 1;
    endtask

    initial begin
        Reset            = 0;
        LoadInstructions = 0;
        Instruction      = '0;
        fif.fetch_req    = 0;
        fif.fetch_addr   = '0;
        foreach (mem_m[i]) mem_m[i] = '0;
        model_reset();
        #12;
        check_outs("rst");
        Reset = 1;

        cyc(1, 32'h200101A7, 0, 0);
        cyc(1, 32'h2002005C, 0, 0);
        cyc(1, 32'h2003000D, 0, 0);
        idle();
        check("t1_len", 64'(prog_len), 64'd3);
        check("t1_rdy", 64'(ready), 64'd1);
        fetch1(0);
        check("t1_d0", 64'(fif.fetch_data), 64'h200101A7);
        fetch1(1);
        check("t1_d1", 64'(fif.fetch_data), 64'h2002005C);
        fetch1(2);
        check("t1_d2", 64'(fif.fetch_data), 64'h2003000D);

        fetch1(3);
        check("t2_oob3", 64'(fif.fetch_oob), 64'd1);
        fetch1(DEPTH - 1);
        check("t2_d", 64'(fif.fetch_data), 64'd0);
        idle();

        for (int i = 1; i <= 6; i++) cyc(1, DW'(i), 0, 0);
        idle();
        check("t3_len", 64'(prog_len), 64'd4);
        check("t3_ovf", 64'(overflow), 64'd1);
        for (int a = 0; a < 4; a++) begin
            fetch1(a);
            check("t3_d", 64'(fif.fetch_data), 64'(a + 1));
        end

        cyc(1, 32'hAAAA0000, 0, 0);
        cyc(1, 32'hBBBB0000, 0, 0);
        idle();
        check("t4_ovf", 64'(overflow), 64'd0);
        check("t4_len", 64'(prog_len), 64'd2);
        fetch1(1);
        check("t4_d1", 64'(fif.fetch_data), 64'hBBBB0000);
        fetch1(2);
        check("t4_oob", 64'(fif.fetch_oob), 64'd1);

        cyc(1, 32'h11, 0, 0);
        cyc(1, 32'h22, 1, 0);
        check("t5_ld_v", 64'(fif.fetch_valid), 64'd0);
        idle();
        cyc(1, 32'h33, 1, 0);
        check("t5_pri_v", 64'(fif.fetch_valid), 64'd0);
        check("t5_pri_len", 64'(prog_len), 64'd1);
        idle();

        fetch1(0);
        arst();
        cyc(1, 32'h5555, 0, 0);
        cyc(1, 32'h6666, 0, 0);
        arst();
        cyc(1, 32'h200101A7, 0, 0);
        cyc(1, 32'h2002005C, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t6_csum", 64'(load_csum), 64'(32'h200101A7 ^ 32'h2002005C));
`endif
        idle();
        fetch1(0);
        check("t6_d0", 64'(fif.fetch_data), 64'h200101A7);

        begin
            int burst = 0;
            for (int n = 0; n < 600; n++) begin
                bit ld;
                if (burst == 0 && $urandom_range(0, 9) == 0)
                    burst = $urandom_range(1, 7);
                ld = (burst > 0);
                if (burst > 0) burst--;
                if ($urandom_range(0, 149) == 0) arst();
                else cyc(ld, DW'($urandom), bit'($urandom_range(0, 1)),
                         $urandom_range(0, DEPTH - 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised instruction memory with a serial load port and a registered fetch port. It generalises the CPU's LoadInstructions/Instruction preload path.
- During load mode, one word is written per clock at consecutive addresses from 0. Once loading ends, the CPU fetch stage reads the loaded program by address.
- Tracks program length, flags overflow, and returns NOP (0) for fetches beyond the loaded program. It sits between the bench/boot source and the CPU fetch stage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of instruction words; must be a power of two, at least 2.
- AW, $clog2(DEPTH), address width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- LoadInstructions  input  1  load mode; while high, Instruction is captured every cycle.
- Instruction  input  DATA_W  word to write at the current load pointer.
- fetch_req  input  1  fetch request, sampled on clk.
- fetch_addr  input  AW  word address to fetch.
- fetch_valid  output  1  fetch_data is valid this cycle.
- fetch_data  output  DATA_W  fetched word, or 0 for out-of-range addresses.
- fetch_oob  output  1  qualifies fetch_valid; 1 when fetch_addr >= prog_len.
- ready  output  1  1 in state READY.
- prog_len  output  AW+1  number of words loaded, 0..DEPTH.
- overflow  output  1  sticky; a load word was dropped because memory was full.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=EMPTY, load pointer=0, prog_len=0, overflow=0.
  - fetch_valid=0, fetch_data=0, fetch_oob=0, ready=0.
  - Memory array is NOT cleared.
- States: EMPTY, LOADING, READY.
- EMPTY:
  - LoadInstructions=1 -> write Instruction at address 0, pointer=1, prog_len=1, go to LOADING.
  - Otherwise stay.
- LOADING:
  - LoadInstructions=1 and prog_len<DEPTH -> write at pointer, pointer+1, prog_len+1.
  - LoadInstructions=1 and prog_len==DEPTH -> word dropped, overflow<=1, no write; pointer and prog_len are held (no wrap-around).
  - LoadInstructions=0 -> go to READY. This cycle's Instruction is not written.
- READY:
  - LoadInstructions=1 -> reload. Write Instruction at address 0, pointer=1, prog_len=1, overflow<=0, go to LOADING.
  - Load has priority over a simultaneous fetch_req; that fetch is dropped (no fetch_valid).
- Fetch:
  - Serviced only when state==READY, fetch_req=1 and LoadInstructions=0.
  - Latency 1 cycle: fetch_valid=1 on the next clk edge, with fetch_data=mem[fetch_addr] if fetch_addr<prog_len, else fetch_data=0 and fetch_oob=1.
  - Back-to-back requests produce back-to-back responses (one per cycle).
  - Cycles with no serviced request: fetch_valid=0, fetch_data holds its previous value, fetch_oob=0.
- fetch_req in EMPTY or LOADING is ignored. There is no queuing.
- Reset mid-load: the load is abandoned, prog_len=0 and state=EMPTY. The next load starts at address 0.
- prog_len == DEPTH is representable, hence the AW+1 width.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output load_csum [DATA_W-1:0], the XOR of all words written since the last load start.
  - Reset value 0. Cleared to the first word on load start from EMPTY or READY.
  - Dropped overflow words do not contribute. The value holds in READY.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package imem_pkg:
  - state enum/localparams ST_EMPTY=2'd0, ST_LOADING=2'd1, ST_READY=2'd2.
  - NOP word constant IMEM_NOP = 0.
- One sub-module, imem_ram: single write port, single registered read port, DATA_W x DEPTH, no reset on the array. Control FSM, counters and flags stay in imem_loader.

Test Plan:
- Load and read back:
  - Stimulus: reset, then load 0x200101A7, 0x2002005C, 0x2003000D, then drop LoadInstructions.
  - Expected: prog_len=3, ready=1. Fetching addresses 0, 1, 2 back-to-back returns those words on consecutive cycles, each with fetch_valid=1 and fetch_oob=0.
- Out of range:
  - Stimulus: after the 3-word load, fetch address 3, then address DEPTH-1.
  - Expected: fetch_data=0, fetch_oob=1, fetch_valid=1 for both.
- Overflow (DEPTH=4):
  - Stimulus: load 6 words 1..6.
  - Expected: prog_len=4, overflow=1. Addresses 0..3 read 1..4; address 0 is not overwritten by 5.
- Reload:
  - Stimulus: in READY with overflow=1, load 2 words 0xAAAA0000 and 0xBBBB0000.
  - Expected: overflow=0, prog_len=2. Address 1 reads 0xBBBB0000; address 2 reads 0 with fetch_oob=1.
- Priority and gating:
  - Stimulus: fetch_req during LOADING; then fetch_req and LoadInstructions together in READY.
  - Expected: no fetch_valid in either case; the second moves state to LOADING with prog_len=1.
- Async reset:
  - Stimulus: assert Reset=0 mid-cycle during LOADING.
  - Expected: prog_len=0, ready=0, fetch_valid=0 immediately, without waiting for clk. The next load restarts at address 0.
  - With IMEM_LOADER_CHECKSUM_EN defined: load_csum is 0 after reset, and 0x200101A7 XOR 0x2002005C after two words.
